mem_wrap_read_responder: RTL and testbench

//  Memory-side responder for the cache-line refill path: accepts one AXI AR request at a time and

---
 rtl/mem_r_pkg.sv | 29 ++
 rtl/mem_wrap_read_responder_if.sv | 32 +++
 rtl/mem_r_line_serializer.sv | 40 ++++
 rtl/mem_wrap_read_responder.sv | 132 +++++++++++++
 tb/tb_mem_wrap_read_responder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_r_pkg.sv
// Shared constants and types for the memory-side WRAP read responder.
package mem_r_pkg;

    localparam int BEATS  = 8;
    localparam int LINE_W = 512;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] ARLEN_LINE  = 4'd7;
    localparam logic [2:0] ARSIZE_8B   = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        WAIT  = 2'b10,
        BURST = 2'b11
    } state_e;

    // Critical-word-first order: the 3-bit sum wraps inside the line.
    function automatic logic [2:0] wrap_idx(input logic [2:0] start, input logic [2:0] beat);
        return start + beat;
    endfunction

endpackage

// File: rtl/mem_wrap_read_responder_if.sv
// AXI AR/R channel bundle for the line refill responder.
// MEM_R_ID_EN adds the arid_i/rid_o pair.
interface mem_wrap_read_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] araddr_i;
    logic [3:0]        arlen_i;
    logic [2:0]        arsize_i;
    logic [1:0]        arburst_i;
    logic              arvalid_i;
    logic              arready_o;
    logic [DATA_W-1:0] rdata_o;
    logic [1:0]        rresp_o;
    logic              rlast_o;
    logic              rvalid_o;
    logic              rready_i;
`ifdef MEM_R_ID_EN
    logic [3:0]        arid_i;
    logic [3:0]        rid_o;

    modport master (output araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i, arid_i,
                    input  arready_o, rdata_o, rresp_o, rlast_o, rvalid_o, rid_o);
    modport slave  (input  araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i, arid_i,
                    output arready_o, rdata_o, rresp_o, rlast_o, rvalid_o, rid_o);
`else
    modport master (output araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
                    input  arready_o, rdata_o, rresp_o, rlast_o, rvalid_o);
    modport slave  (input  araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
                    output arready_o, rdata_o, rresp_o, rlast_o, rvalid_o);
`endif
endinterface

// File: rtl/mem_r_line_serializer.sv
// Holds one refill line and walks its words in wrap order, one per accepted beat.
module mem_r_line_serializer #(
    parameter int LINE_W = 512,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              advance_i,
    input  logic [2:0]        start_i,
    output logic [DATA_W-1:0] word_o,
    output logic              last_o
);
    import mem_r_pkg::*;

    localparam int NBEATS = LINE_W / DATA_W;

    logic [LINE_W-1:0] buf_q;
    logic [2:0]        beat_q;
    logic [2:0]        idx_s;

    // Line buffer capture and beat counter; loading a new line restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q  <= '0;
            beat_q <= 3'd0;
        end else if (load_i) begin
            buf_q  <= line_i;
            beat_q <= 3'd0;
        end else if (advance_i) begin
            beat_q <= beat_q + 3'd1;
        end
    end

    assign idx_s  = wrap_idx(start_i, beat_q);
    assign word_o = buf_q[int'(idx_s)*DATA_W +: DATA_W];
    assign last_o = (beat_q == 3'(NBEATS - 1));

endmodule

// File: rtl/mem_wrap_read_responder.sv
// Refill-path responder: one AR at a time, line read, then an 8-beat WRAP burst.
// Optional MEM_R_ID_EN carries arid_i through to rid_o.
module mem_wrap_read_responder #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int LINE_W   = 512,
    parameter int INIT_LAT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mem_wrap_read_responder_if.slave bus,
    output logic                    line_rden_o,
    output logic [ADDR_W-7:0]       line_raddr_o,
    input  logic [LINE_W-1:0]       line_rdata_i
);
    import mem_r_pkg::*;

    state_e            state_q, state_d;
    logic [7:0]        lat_q, lat_d;
    logic [2:0]        start_q;
    logic              err_q;
    logic              err_s;
    logic              capture_s;
    logic              load_s;
    logic              advance_s;
    logic              last_s;
    logic              burst_s;
    logic [DATA_W-1:0] word_s;
    logic              unused_addr_bits;

    assign err_s = (bus.arlen_i != ARLEN_LINE) || (bus.arsize_i != ARSIZE_8B) ||
                   (bus.arburst_i != BURST_WRAP);

    // Next-state logic for the request/fetch/wait/burst sequence.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        capture_s = 1'b0;
        load_s    = 1'b0;
        advance_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.arvalid_i) begin
                    capture_s = 1'b1;
                    state_d   = FETCH;
                end else begin
                    state_d   = IDLE;
                end
            end
            FETCH: begin
                load_s  = 1'b1;
                lat_d   = 8'(INIT_LAT);
                state_d = (INIT_LAT == 0) ? BURST : WAIT;
            end
            WAIT: begin
                if (lat_q <= 8'd1) begin
                    state_d = BURST;
                end else begin
                    lat_d   = lat_q - 8'd1;
                end
            end
            BURST: begin
                advance_s = bus.rready_i;
                if (bus.rready_i && last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BURST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latency counter and AR capture registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lat_q   <= 8'd0;
            start_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (capture_s) begin
                start_q <= bus.araddr_i[5:3];
                err_q   <= err_s;
            end
        end
    end

`ifdef MEM_R_ID_EN
    logic [3:0] id_q;

    // Request ID is held for every beat of the burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q <= 4'd0;
        end else if (capture_s) begin
            id_q <= bus.arid_i;
        end
    end

    assign bus.rid_o = id_q;
`endif

    mem_r_line_serializer #(
        .LINE_W (LINE_W),
        .DATA_W (DATA_W)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_s),
        .line_i    (line_rdata_i),
        .advance_i (advance_s),
        .start_i   (start_q),
        .word_o    (word_s),
        .last_o    (last_s)
    );

    // Error bursts still run 8 beats but carry zero data so no stale line leaks out.
    assign burst_s       = (state_q == BURST);
    assign bus.arready_o = (state_q == IDLE);
    assign bus.rvalid_o  = burst_s;
    assign bus.rdata_o   = (burst_s && !err_q) ? word_s : {DATA_W{1'b0}};
    assign bus.rresp_o   = (burst_s && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign bus.rlast_o   = burst_s && last_s;
    assign line_rden_o   = capture_s;
    assign line_raddr_o  = capture_s ? bus.araddr_i[ADDR_W-1:6] : {(ADDR_W-6){1'b0}};

    assign unused_addr_bits = ^bus.araddr_i[2:0];

endmodule

// File: tb/tb_mem_wrap_read_responder.sv
// Scoreboard bench for mem_wrap_read_responder: directed WRAP bursts, backpressure, errors, reset.
module tb_mem_wrap_read_responder;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int LINE_W   = 512;
    localparam int INIT_LAT = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                line_rden;
    logic [ADDR_W-7:0]   line_raddr;
    logic [LINE_W-1:0]   line_rdata;

    always #5 clk = ~clk;

    mem_wrap_read_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_wrap_read_responder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LINE_W   (LINE_W),
        .INIT_LAT (INIT_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .line_rden_o  (line_rden),
        .line_raddr_o (line_raddr),
        .line_rdata_i (line_rdata)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t exp_m;
    beat_t held;
    bit    hold_v = 1'b0;
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word(input logic [25:0] li, input int k);
        return {6'b0, li, 32'hF00D_0000 + 32'(k)};
    endfunction

    // Line storage model: data one cycle after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (line_rden) begin
            for (int k = 0; k < 8; k++) line_rdata[k*64 +: 64] <= word(line_raddr, k);
        end else begin
            line_rdata <= {8{64'hDEAD_BEEF_DEAD_BEEF}};
        end
    end

    // Monitor: stability under stall, then pop and compare on every accepted beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_rvalid", 64'(bus.rvalid_o), 64'd1);
                chk("hold_rdata", bus.rdata_o, held.data);
                chk("hold_rresp", 64'(bus.rresp_o), 64'(held.resp));
                chk("hold_rlast", 64'(bus.rlast_o), 64'(held.last));
            end
            if (bus.rvalid_o && !bus.rready_i) begin
                hold_v = 1'b1;
                held   = '{data: bus.rdata_o, resp: bus.rresp_o, last: bus.rlast_o};
            end else begin
                hold_v = 1'b0;
            end
            if (bus.rvalid_o && bus.rready_i) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %h, expected no beat", bus.rdata_o);
                end else begin
                    exp_m = exp_q.pop_front();
                    chk("rdata", bus.rdata_o, exp_m.data);
                    chk("rresp", 64'(bus.rresp_o), 64'(exp_m.resp));
                    chk("rlast", 64'(bus.rlast_o), 64'(exp_m.last));
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] addr, input bit err, input int n);
        logic [2:0] st;
        beat_t      x;
        st = addr[5:3];
        for (int b = 0; b < n; b++) begin
            x.data = err ? 64'd0 : word(addr[31:6], (int'(st) + b) % 8);
            x.resp = err ? 2'b10 : 2'b00;
            x.last = (b == 7);
            exp_q.push_back(x);
        end
    endtask

    // Issues one AR, checks strobe/latency, runs the R handshakes; abort_at<8 resets mid-burst.
    task automatic run_burst(input string tag, input logic [31:0] addr, input logic [1:0] burst,
                             input logic [7:0] stall_mask, input int abort_at);
        int cnt;
        int beat;
        int stall;
        int guard;
        bit hs;
        bit st;
        push_exp(addr, (burst != 2'b10), abort_at);
        bus.araddr_i  = addr;
        bus.arlen_i   = 4'd7;
        bus.arsize_i  = 3'd3;
        bus.arburst_i = burst;
        bus.arvalid_i = 1'b1;
        bus.rready_i  = !stall_mask[0];
        stall         = stall_mask[0] ? 3 : 0;
        @(negedge clk);
        chk({tag, "_arready"}, 64'(bus.arready_o), 64'd1);
        chk({tag, "_line_rden"}, 64'(line_rden), 64'd1);
        chk({tag, "_line_raddr"}, 64'(line_raddr), 64'(addr[31:6]));
        @(posedge clk);
        #1;
        bus.arvalid_i = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.rvalid_o && cnt < 40);
        chk({tag, "_latency"}, 64'(cnt), 64'(2 + INIT_LAT));
        beat  = 0;
        guard = 0;
        while (beat < 8 && guard < 200) begin
            hs = bus.rvalid_o && bus.rready_i;
            st = bus.rvalid_o && !bus.rready_i;
            guard++;
            @(posedge clk);
            #1;
            if (hs) begin
                beat++;
                if (beat == abort_at) begin
                    rst_n = 1'b0;
                    @(posedge clk);
                    #1;
                    chk({tag, "_rvalid_after_reset"}, 64'(bus.rvalid_o), 64'd0);
                    chk({tag, "_arready_after_reset"}, 64'(bus.arready_o), 64'd1);
                    rst_n        = 1'b1;
                    bus.rready_i = 1'b1;
                    return;
                end
                if (beat < 8 && stall_mask[beat]) begin
                    bus.rready_i = 1'b0;
                    stall        = 3;
                end
            end else if (st && stall > 0) begin
                stall--;
                if (stall == 0) bus.rready_i = 1'b1;
            end
            if (beat < 8) @(negedge clk);
        end
        chk({tag, "_beats"}, 64'(beat), 64'd8);
        chk({tag, "_arready_after_last"}, 64'(bus.arready_o), 64'd1);
        chk({tag, "_rvalid_after_last"}, 64'(bus.rvalid_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.araddr_i  = '0;
        bus.arlen_i   = 4'd0;
        bus.arsize_i  = 3'd0;
        bus.arburst_i = 2'b00;
        bus.arvalid_i = 1'b0;
        bus.rready_i  = 1'b1;
`ifdef MEM_R_ID_EN
        bus.arid_i    = 4'h3;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_arready", 64'(bus.arready_o), 64'd1);
        chk("reset_rvalid", 64'(bus.rvalid_o), 64'd0);
        chk("reset_rlast", 64'(bus.rlast_o), 64'd0);
        chk("reset_rresp", 64'(bus.rresp_o), 64'd0);
        chk("reset_rdata", bus.rdata_o, 64'd0);
        chk("reset_line_rden", 64'(line_rden), 64'd0);
        chk("reset_line_raddr", 64'(line_raddr), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_burst("t2_start0", 32'h0000_1040, 2'b10, 8'h00, 8);
        run_burst("t3_start5", 32'h0000_1068, 2'b10, 8'h00, 8);
        run_burst("t4_stall", 32'h0000_1068, 2'b10, 8'b0100_0100, 8);
        run_burst("t5_incr_err", 32'h2000_0F18, 2'b01, 8'h00, 8);
        run_burst("t5_next_ar", 32'h0000_2FF0, 2'b10, 8'h01, 8);
        run_burst("t6_abort", 32'h0000_1078, 2'b10, 8'h00, 3);
        run_burst("t6_after", 32'h0000_3010, 2'b10, 8'h00, 8);

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
